// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg
//   Shared definitions for the seven-segment scan capture block: the
//   capture FSM state encoding, the active-low hex glyph table, the blank
//   digit-select value, the default timing parameters and a small helper
//   that turns a one-hot-low digit select into a digit index.
package seg_scan_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        CAPT = 1'b1
    } scan_state_t;

    localparam int SETTLE_DEFAULT  = 4;
    localparam int TIMEOUT_DEFAULT = 65536;

    // All digit selects inactive: no digit is being driven.
    localparam logic [7:0] AN_BLANK = 8'hFF;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}; entry n shows hex digit n.
    localparam logic [15:0][6:0] GLYPH = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Index of the (highest) active-low select bit. Only meaningful when
    // exactly one bit of an is low.
    function automatic logic [2:0] sel_index(input logic [7:0] an);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (!an[k]) begin
                idx = 3'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational seven-segment to hex decoder; inverse of the hex to
//   segment encoder used elsewhere.
//   Ports:
//     seg     in  7  active-low segments {g,f,e,d,c,b,a}
//     nibble  out 4  decoded hex digit (0 when the pattern is not a glyph)
//     illegal out 1  1 when seg matches none of the 16 hex glyphs
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       illegal
);

    always_comb begin
        nibble  = 4'd0;
        illegal = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPH[i]) begin
                nibble  = 4'(i);
                illegal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Reconstructs the value shown on a multiplexed 8-digit seven-segment
//   display by watching its segment and digit-select lines.
//   Ports:
//     clk         in   1  clock, rising edge
//     rstn        in   1  asynchronous active-low reset
//     seg         in   8  active-low segments, seg[7] = decimal point
//     an          in   8  active-low digit select, digit 0 rightmost
//     value       out 32  last complete frame, nibble k = digit k
//     dp          out  8  last complete frame decimal points, 1 = lit
//     frame_valid out  1  one-cycle pulse when value/dp/frame_err update
//     frame_err   out  1  frame held an undecodable glyph (qualifies frame_valid)
//     locked      out  1  a consistent 0..7 scan is being tracked
//     order_err   out  1  one-cycle pulse on out-of-order or multi-hot select
//     scan_state  out  1  capture FSM state, 0 = HUNT, 1 = CAPT
//   Output handshake: frame_valid and order_err are pure one-cycle strobes
//   with no back-pressure; value, dp and frame_err are stable from the
//   frame_valid cycle until the next frame_valid.
//
//   Pipeline: inputs are registered once; a digit select that stays
//   unchanged for SETTLE cycles yields one sample, which is registered and
//   consumed by the FSM on the following edge.
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int SETTLE  = SETTLE_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  seg,
    input  logic [7:0]  an,
    output logic [31:0] value,
    output logic [7:0]  dp,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        locked,
    output logic        order_err,
    output logic        scan_state
);

    localparam int         TW      = $clog2(TIMEOUT + 1);
    localparam logic [7:0] SETTLE8 = 8'(SETTLE);

    // Registered inputs and the select from the cycle before.
    logic [7:0] seg_q;
    logic [7:0] an_q;
    logic [7:0] an_p;

    logic [7:0] stab_cnt;
    logic [7:0] stab_cnt_next;
    logic       sel_blank;
    logic       sel_changed;
    logic       sel_onehot;
    logic       fire;

    logic [TW-1:0] idle_cnt;
    logic          timeout_hit;

    logic [3:0] dec_nib;
    logic       dec_ill;

    // Sample register: one entry per settled slot.
    logic       samp_v;
    logic       samp_multi;
    logic [2:0] samp_idx;
    logic [3:0] samp_nib;
    logic       samp_ill;
    logic       samp_dp;

    // FSM state and partial frame.
    scan_state_t state, state_n;
    logic [2:0]  exp_idx, exp_idx_n;
    logic [31:0] part_val, part_val_n;
    logic [7:0]  part_dp, part_dp_n;
    logic        part_bad, part_bad_n;
    logic [31:0] value_n;
    logic [7:0]  dp_n;
    logic        frame_err_n;
    logic        frame_valid_n;
    logic        locked_n;
    logic        order_err_n;
    logic        abort;
    logic        drop;

    seg7_decode u_decode (
        .seg     (seg_q[6:0]),
        .nibble  (dec_nib),
        .illegal (dec_ill)
    );

    // Stability tracking. stab_cnt_next is the number of cycles an_q has
    // held its current value, saturating at SETTLE. A sample fires only on
    // the edge the count first reaches SETTLE, so a long slot still gives
    // exactly one sample and a short one gives none.
    always_comb begin
        sel_blank   = (an_q == AN_BLANK);
        sel_changed = (an_q != an_p);
        sel_onehot  = $onehot(~an_q);

        stab_cnt_next = stab_cnt;
        if (sel_blank) begin
            stab_cnt_next = 8'd0;
        end else if (sel_changed) begin
            stab_cnt_next = 8'd1;
        end else if (stab_cnt != SETTLE8) begin
            stab_cnt_next = stab_cnt + 8'd1;
        end

        fire = !sel_blank && (stab_cnt_next == SETTLE8) &&
               (sel_changed || (stab_cnt != SETTLE8));

        // Fires once, on the edge the idle count reaches TIMEOUT. A sample
        // on the same edge restarts the count instead.
        timeout_hit = !fire && (idle_cnt == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seg_q      <= 8'hFF;
            an_q       <= AN_BLANK;
            an_p       <= AN_BLANK;
            stab_cnt   <= 8'd0;
            idle_cnt   <= '0;
            samp_v     <= 1'b0;
            samp_multi <= 1'b0;
            samp_idx   <= 3'd0;
            samp_nib   <= 4'd0;
            samp_ill   <= 1'b0;
            samp_dp    <= 1'b0;
        end else begin
            seg_q    <= seg;
            an_q     <= an;
            an_p     <= an_q;
            stab_cnt <= stab_cnt_next;

            if (fire) begin
                idle_cnt <= '0;
            end else if (idle_cnt != TW'(TIMEOUT)) begin
                idle_cnt <= idle_cnt + TW'(1);
            end

            samp_v     <= fire;
            samp_multi <= !sel_onehot;
            samp_idx   <= sel_index(an_q);
            samp_nib   <= dec_nib;
            samp_ill   <= dec_ill;
            samp_dp    <= ~seg_q[7];
        end
    end

    // Capture FSM: HUNT waits for digit 0, CAPT collects digits in order
    // and publishes after digit 7.
    always_comb begin
        state_n       = state;
        exp_idx_n     = exp_idx;
        part_val_n    = part_val;
        part_dp_n     = part_dp;
        part_bad_n    = part_bad;
        value_n       = value;
        dp_n          = dp;
        frame_err_n   = frame_err;
        locked_n      = locked;
        frame_valid_n = 1'b0;
        order_err_n   = 1'b0;
        abort         = 1'b0;
        drop          = 1'b0;

        if (samp_v) begin
            if (samp_multi) begin
                // Multi-hot selects only matter while a frame is in flight.
                abort = (state == CAPT);
            end else if (state == HUNT) begin
                if (samp_idx == 3'd0) begin
                    part_val_n = {28'd0, samp_nib};
                    part_dp_n  = {7'd0, samp_dp};
                    part_bad_n = samp_ill;
                    exp_idx_n  = 3'd1;
                    state_n    = CAPT;
                end
            end else if (samp_idx != exp_idx) begin
                abort = 1'b1;
            end else begin
                if (samp_idx == 3'd0) begin
                    // New frame: previous frame's error flag does not carry over.
                    part_val_n = {28'd0, samp_nib};
                    part_dp_n  = {7'd0, samp_dp};
                    part_bad_n = samp_ill;
                end else begin
                    part_val_n[{samp_idx, 2'b00} +: 4] = samp_nib;
                    part_dp_n[samp_idx]                = samp_dp;
                    part_bad_n                         = part_bad | samp_ill;
                end
                exp_idx_n = exp_idx + 3'd1;  // 7 wraps to 0
                if (samp_idx == 3'd7) begin
                    value_n       = part_val_n;
                    dp_n          = part_dp_n;
                    frame_err_n   = part_bad_n;
                    frame_valid_n = 1'b1;
                    locked_n      = 1'b1;
                end
            end
        end else if (timeout_hit) begin
            drop = 1'b1;
        end

        if (abort || drop) begin
            state_n    = HUNT;
            exp_idx_n  = 3'd0;
            part_val_n = 32'd0;
            part_dp_n  = 8'd0;
            part_bad_n = 1'b0;
            locked_n   = 1'b0;
        end
        order_err_n = abort;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= HUNT;
            exp_idx     <= 3'd0;
            part_val    <= 32'd0;
            part_dp     <= 8'd0;
            part_bad    <= 1'b0;
            value       <= 32'd0;
            dp          <= 8'd0;
            frame_err   <= 1'b0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            order_err   <= 1'b0;
        end else begin
            state       <= state_n;
            exp_idx     <= exp_idx_n;
            part_val    <= part_val_n;
            part_dp     <= part_dp_n;
            part_bad    <= part_bad_n;
            value       <= value_n;
            dp          <= dp_n;
            frame_err   <= frame_err_n;
            frame_valid <= frame_valid_n;
            locked      <= locked_n;
            order_err   <= order_err_n;
        end
    end

    assign scan_state = (state == CAPT);

endmodule

// File: tb/tb_seg_scan_capture.sv
`timescale 1ns/1ps
module tb_seg_scan_capture;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 200;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  seg  = 8'hFF;
    logic [7:0]  an   = 8'hFF;
    logic [31:0] value;
    logic [7:0]  dp;
    logic        frame_valid;
    logic        frame_err;
    logic        locked;
    logic        order_err;
    logic        scan_state;

    seg_scan_capture #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .dp          (dp),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .locked      (locked),
        .order_err   (order_err),
        .scan_state  (scan_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int passes = 0;
    int frames = 0;
    int oe_cnt = 0;
    int t7_cyc = 0;

    // Expected frames: {frame_err, dp, value}
    logic [40:0] exp_q[$];

    // Active-low glyphs {g..a}, independent hand-written table.
    logic [6:0] glyph_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [40:0] e;
        if (rstn) begin
            if (order_err) oe_cnt++;
            if (frame_valid) begin
                frames++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL frame_unexpected: got value %0h dp %0h, expected no frame (cycle %0d)",
                             value, dp, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_value", value, e[31:0]);
                    check("frame_dp", dp, e[39:32]);
                    check("frame_err", frame_err, e[40]);
                    check("locked_at_frame", locked, 1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drive one digit slot starting at a negedge; optionally check the
    // exact publication cycle when this is the closing digit 7.
    task automatic slot(input int k, input logic [3:0] nib, input logic dpb,
                        input bit bad, input int len, input bit pub);
        an  = ~(8'(1) << k);
        seg = {~dpb, bad ? 7'h7F : glyph_tab[nib]};
        if (k == 7) t7_cyc = cyc;
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            if (pub && i == SETTLE + 1) check("pub_not_early", frame_valid, 0);
            if (pub && i == SETTLE + 2) check("pub_timing", frame_valid, 1);
        end
    endtask

    task automatic raw_slot(input logic [7:0] an_v, input int len);
        an  = an_v;
        seg = {1'b1, glyph_tab[0]};
        repeat (len) @(negedge clk);
    endtask

    // Scan digits first..7 (skipping 'skip'); 'bad' digit gets an
    // undecodable glyph. Pushes the expected frame when one should publish.
    task automatic round(input logic [31:0] v, input logic [7:0] d, input int first,
                         input int skip, input int bad, input bit expect_pub);
        logic [31:0] ev;
        ev = v;
        if (bad >= 0) ev[bad*4 +: 4] = 4'd0;
        if (expect_pub) exp_q.push_back({bad >= 0, d, ev});
        for (int k = first; k < 8; k++) begin
            if (k != skip) slot(k, v[k*4 +: 4], d[k], k == bad, 8, expect_pub && k == 7);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_value"}, value, 0);
        check({tag, "_dp"}, dp, 0);
        check({tag, "_frame_valid"}, frame_valid, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_order_err"}, order_err, 0);
        check({tag, "_state"}, scan_state, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int oe0;
        int fr0;
        int c0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Two clean rounds from HUNT
        round(32'h1234ABCD, 8'h08, 0, -1, -1, 1);
        round(32'h1234ABCD, 8'h08, 0, -1, -1, 1);
        check("frames_two_rounds", frames, 2);
        check("locked_after_rounds", locked, 1);
        check("no_order_err", oe_cnt, 0);

        // Undecodable glyph on digit 2, then a clean frame
        round(32'h1234ABCD, 8'h08, 0, -1, 2, 1);
        round(32'h1234ABCD, 8'h08, 0, -1, -1, 1);

        // Skip digit 4
        oe0 = oe_cnt;
        fr0 = frames;
        round(32'h1234ABCD, 8'h08, 0, 4, -1, 0);
        check("skip_order_err", oe_cnt - oe0, 1);
        check("skip_unlocked", locked, 0);
        check("skip_value_held", value, 32'h1234ABCD);
        check("skip_state_hunt", scan_state, 0);

        // Start mid-scan at digit 5: nothing publishes
        round(32'hFEDC0123, 8'h81, 5, -1, -1, 0);
        check("mid_start_no_frame", frames - fr0, 0);
        check("mid_start_no_order_err", oe_cnt - oe0, 1);
        check("mid_start_value_held", value, 32'h1234ABCD);
        round(32'hFEDC0123, 8'h81, 0, -1, -1, 1);
        check("relock", locked, 1);

        // Multi-hot select: error in CAPT, ignored in HUNT
        oe0 = oe_cnt;
        slot(0, 4'hD, 1'b0, 1'b0, 8, 1'b0);
        slot(1, 4'hC, 1'b0, 1'b0, 8, 1'b0);
        raw_slot(8'b1111_0011, 8);
        check("multihot_capt_err", oe_cnt - oe0, 1);
        check("multihot_unlocked", locked, 0);
        raw_slot(8'b0000_0000, 8);
        check("multihot_hunt_ignored", oe_cnt - oe0, 1);
        check("multihot_value_held", value, 32'hFEDC0123);
        round(32'h1234ABCD, 8'h08, 0, -1, -1, 1);

        // Short slots then blank: exact timeout from the last digit-7 sample
        c0  = t7_cyc;
        oe0 = oe_cnt;
        fr0 = frames;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) slot(k, 4'h5, 1'b0, 1'b0, 3, 1'b0);
        end
        an  = 8'hFF;
        seg = 8'hFF;
        while (cyc < c0 + SETTLE + TIMEOUT) @(negedge clk);
        check("short_slots_no_order_err", oe_cnt - oe0, 0);
        check("short_slots_no_frame", frames - fr0, 0);
        check("locked_before_timeout", locked, 1);
        @(negedge clk);
        check("locked_at_timeout", locked, 0);
        check("timeout_state_hunt", scan_state, 0);
        check("timeout_no_order_err", oe_cnt - oe0, 0);
        check("timeout_value_held", value, 32'h1234ABCD);
        check("timeout_dp_held", dp, 8'h08);

        // Reset mid-frame
        fr0 = frames;
        for (int k = 0; k < 4; k++) slot(k, 4'(k + 8), 1'b0, 1'b0, 8, 1'b0);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("midreset");
        rstn = 1'b1;
        round(32'h5A6B7C8D, 8'h42, 4, -1, -1, 0);
        check("after_reset_no_frame", frames - fr0, 0);
        round(32'h5A6B7C8D, 8'h42, 0, -1, -1, 1);
        check("after_reset_value", value, 32'h5A6B7C8D);
        check("after_reset_locked", locked, 1);

        an = 8'hFF;
        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
